// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential instruction fetch from a combinational ROM into a
// two-entry queue, with redirect and a sticky fault on an illegal PC.
//
// Output handshake: the head entry is transferred on any rising edge where
// out_valid and out_ready are both 1. While out_valid is 1, out_instr and
// out_pc do not change until that transfer happens or a redirect/reset
// flushes the queue. out_ready may be driven in any way and does not depend
// on out_valid.
module fetch_ctrl #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] fetch_count,
    output logic        dbg_state
);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] s0_instr, s0_instr_n, s1_instr, s1_instr_n;
    logic [63:0] s0_pc, s0_pc_n, s1_pc, s1_pc_n;
    logic [63:0] fault_pc_n;
    logic [31:0] fetch_count_n;
    logic        pop, push, legal;

    // Slot 0 is always the queue head, so outputs come straight from registers.
    assign imem_addr = pc;
    assign out_valid = (cnt != 2'd0);
    assign out_instr = s0_instr;
    assign out_pc    = s0_pc;
    assign fault     = (state == FAULT);
    assign dbg_state = state;
    assign pop       = out_valid & out_ready;

    // Widen by one bit so pc+3 cannot wrap for addresses near 2^64.
    assign legal = (pc[1:0] == 2'b00) &&
                   (({1'b0, pc} + 65'd3) < 65'(MEM_SIZE));

    // Next-state logic: redirect beats everything, then fault/push/pop.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        cnt_n         = cnt;
        s0_instr_n    = s0_instr;
        s0_pc_n       = s0_pc;
        s1_instr_n    = s1_instr;
        s1_pc_n       = s1_pc;
        fault_pc_n    = fault_pc;
        fetch_count_n = fetch_count;
        push          = 1'b0;
        if (redirect_valid) begin
            cnt_n   = 2'd0;
            pc_n    = redirect_pc;
            state_n = RUN;
        end else begin
            if (pop) begin
                fetch_count_n = fetch_count + 32'd1;
            end
            if (state == RUN) begin
                if (!legal) begin
                    state_n    = FAULT;
                    fault_pc_n = pc;
                end else if ((cnt != 2'd2) || pop) begin
                    push = 1'b1;
                end
            end
            if (push) begin
                pc_n = pc + 64'd4;
            end
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        s0_instr_n = imem_instr;
                        s0_pc_n    = pc;
                    end else begin
                        s1_instr_n = imem_instr;
                        s1_pc_n    = pc;
                    end
                    cnt_n = cnt + 2'd1;
                end
                2'b01: begin
                    s0_instr_n = s1_instr;
                    s0_pc_n    = s1_pc;
                    cnt_n      = cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        s0_instr_n = imem_instr;
                        s0_pc_n    = pc;
                    end else begin
                        s0_instr_n = s1_instr;
                        s0_pc_n    = s1_pc;
                        s1_instr_n = imem_instr;
                        s1_pc_n    = pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers; reset overrides redirect and flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            cnt         <= 2'd0;
            s0_instr    <= 32'd0;
            s0_pc       <= 64'd0;
            s1_instr    <= 32'd0;
            s1_pc       <= 64'd0;
            fault_pc    <= 64'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            cnt         <= cnt_n;
            s0_instr    <= s0_instr_n;
            s0_pc       <= s0_pc_n;
            s1_instr    <= s1_instr_n;
            s1_pc       <= s1_pc_n;
            fault_pc    <= fault_pc_n;
            fetch_count <= fetch_count_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl against hand-computed values.
// ROM word at byte address a (a < 1024) is 32'h1000_0000 + a/4.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] fetch_count;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] fc_saved;

    fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc),
        .fetch_count(fetch_count), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a < 64'd1024) return 32'h1000_0000 + 32'(a[63:2]);
        return 32'hBAD0_BAD0;
    endfunction

    assign imem_instr = rom_word(imem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b1;
        #2;

        // Reset state
        do_reset();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_fcnt", {32'd0, fetch_count}, 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_fpc", fault_pc, 64'd0);

        // Streaming A,B,C,D at one per cycle, first output in cycle 1
        for (int i = 0; i < 4; i++) begin
            step();
            chk("str_valid", {63'd0, out_valid}, 64'd1);
            chk("str_pc", out_pc, 64'(4 * i));
            chk("str_instr", {32'd0, out_instr}, {32'd0, 32'h1000_0000 + 32'(i)});
        end
        step();
        chk("str_fcnt", {32'd0, fetch_count}, 64'd4);

        // Backpressure: hold 5 cycles, queue keeps 0 and 4, pc stalls at 8
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head", out_pc, 64'd0);
        chk("bp_addr", imem_addr, 64'd8);
        chk("bp_fcnt", {32'd0, fetch_count}, 64'd0);
        exp_q.push_back(64'd4); exp_q.push_back(64'd8); exp_q.push_back(64'd12);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            step();
            chk("bp_seq", out_pc, e);
        end
        chk("bp_fcnt3", {32'd0, fetch_count}, 64'd3);

        // Redirect while full, with a coincident handshake that must not count
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid", {63'd0, out_valid}, 64'd0);
        chk("rd_addr", imem_addr, 64'h40);
        chk("rd_fcnt", {32'd0, fetch_count}, 64'd3);
        step();
        chk("rd_pc", out_pc, 64'h40);
        chk("rd_instr", {32'd0, out_instr}, {32'd0, 32'h1000_0010});
        chk("rd_fcnt2", {32'd0, fetch_count}, 64'd3);

        // Last word then out-of-bounds fault
        redirect_valid = 1'b1; redirect_pc = 64'h3FC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("ob_pc", out_pc, 64'h3FC);
        chk("ob_instr", {32'd0, out_instr}, {32'd0, 32'h1000_00FF});
        chk("ob_nofault", {63'd0, fault}, 64'd0);
        step();
        chk("ob_fault", {63'd0, fault}, 64'd1);
        chk("ob_fpc", fault_pc, 64'h400);
        chk("ob_valid", {63'd0, out_valid}, 64'd0);
        chk("ob_addr", imem_addr, 64'h400);
        step(); step();
        chk("ob_hold_v", {63'd0, out_valid}, 64'd0);
        chk("ob_hold_f", {63'd0, fault}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        chk("ob_clr", {63'd0, fault}, 64'd0);
        step();
        chk("ob_res_v", {63'd0, out_valid}, 64'd1);
        chk("ob_res_pc", out_pc, 64'h0);
        chk("ob_res_i", {32'd0, out_instr}, {32'd0, 32'h1000_0000});

        // Misaligned redirect faults on the next cycle with no push
        redirect_valid = 1'b1; redirect_pc = 64'h6;
        step();
        redirect_valid = 1'b0;
        fc_saved = fetch_count;
        chk("ma_nofault", {63'd0, fault}, 64'd0);
        step();
        chk("ma_fault", {63'd0, fault}, 64'd1);
        chk("ma_fpc", fault_pc, 64'h6);
        chk("ma_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("ma_fcnt", {32'd0, fetch_count}, {32'd0, fc_saved});
        do_reset();
        chk("ma_rst_f", {63'd0, fault}, 64'd0);
        chk("ma_rst_pc", imem_addr, 64'h0);
        chk("ma_rst_cnt", {32'd0, fetch_count}, 64'd0);
        chk("ma_rst_fpc", fault_pc, 64'd0);

        // Queue still drains after fault
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h3F8;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        out_ready = 1'b1;
        step();
        chk("dr_fault", {63'd0, fault}, 64'd1);
        chk("dr_valid", {63'd0, out_valid}, 64'd1);
        chk("dr_pc", out_pc, 64'h3FC);
        step();
        chk("dr_empty", {63'd0, out_valid}, 64'd0);
        chk("dr_fault2", {63'd0, fault}, 64'd1);
        chk("dr_fcnt", {32'd0, fetch_count}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter MEM_SIZE, default 1024: instruction memory size in bytes; power of two, >4.
REQ-002 Parameter RESET_PC, default 64'h0: byte address of the first fetch after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  64  byte address presented to the combinational instruction ROM.
REQ-006 imem_instr  input  32  ROM read data for imem_addr, valid in the same cycle.
REQ-007 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc (branch/exception).
REQ-008 redirect_pc  input  64  new fetch address, sampled when redirect_valid=1.
REQ-009 out_valid  output  1  fetch-queue head holds an instruction.
REQ-010 out_ready  input  1  consumer accepts the head this cycle.
REQ-011 out_instr  output  32  instruction at queue head.
REQ-012 out_pc  output  64  byte address of out_instr.
REQ-013 fault  output  1  fetch halted on a misaligned or out-of-bounds PC.
REQ-014 fault_pc  output  64  PC that caused the fault.
REQ-015 fetch_count  output  32  count of accepted instructions (out_valid & out_ready); wraps at 2^32.

Function
REQ-016 The block SHALL hold a 64-bit pc register, a 2-entry FIFO of {instr, pc}, and a state register with states RUN and FAULT.
REQ-017 imem_addr SHALL equal pc combinationally in every cycle, including in FAULT.
REQ-018 pop = out_valid & out_ready; out_valid/out_instr/out_pc SHALL come from FIFO head registers only (no ROM-to-output path).
REQ-019 A fetch is legal when pc[1:0]==0 and pc+3 < MEM_SIZE.
REQ-020 In RUN with no redirect, push SHALL occur when the fetch is legal and (count<2 or pop); push writes {imem_instr, pc} and sets pc <= pc+4.
REQ-021 Push and pop in the same cycle with count==2 SHALL keep count at 2 and preserve order.
REQ-022 In RUN, if count==2 and no pop, pc SHALL hold and no push SHALL occur (stall).
REQ-023 In RUN with no redirect, an illegal fetch SHALL cause no push, state <= FAULT, fault_pc <= pc, pc held.
REQ-024 In FAULT: no pushes; FIFO continues to drain via pop; fault=1; state stays FAULT until redirect or reset.
REQ-025 fault SHALL be 1 exactly when state==FAULT (registered).
REQ-026 redirect_valid SHALL have priority over push, pop, stall and fault in both states: FIFO cleared (count<=0), pc <= redirect_pc, state <= RUN, fault_pc unchanged; a handshake in that cycle SHALL NOT increment fetch_count.
REQ-027 Legality of redirect_pc SHALL be checked on the following cycle by REQ-023, not at redirect.
REQ-028 Latency: instruction fetched in cycle t SHALL appear on out_valid in cycle t+1 at the earliest.
REQ-029 Sustained throughput SHALL be one instruction per cycle while out_ready=1 and fetches are legal.
REQ-030 fetch_count SHALL increment by 1 on each pop not coincident with redirect.

Reset
REQ-031 On reset=1 at a rising edge: pc<=RESET_PC, FIFO empty, out_valid=0, state<=RUN, fault=0, fault_pc<=0, fetch_count<=0; reset overrides redirect.
REQ-032 Reset asserted mid-stream SHALL discard all queued instructions; out_instr/out_pc values while out_valid=0 are don't-care.
REQ-033 First fetch SHALL occur in the first cycle with reset=0.

Verification
REQ-034 Reset, out_ready=1, ROM words 0..3 = A,B,C,D -> out_valid from cycle 1, out_pc 0,4,8,12 with A,B,C,D one per cycle, fetch_count=4 after 4 handshakes.
REQ-035 out_ready=0 for 5 cycles after reset -> FIFO holds pc 0 and 4, pc stalls at 8, imem_addr=8; release out_ready -> 0,4,8 delivered back-to-back, no loss or duplication.
REQ-036 redirect_valid with redirect_pc=0x40 while FIFO full -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40, instruction = mem[16].
REQ-037 redirect_pc=0x3FC, out_ready=1 -> instruction at 0x3FC delivered, then pc=0x400 triggers fault=1, fault_pc=0x400, no further out_valid; redirect to 0x0 clears fault and resumes at 0.
REQ-038 redirect_pc=0x6 -> fault=1 next cycle, fault_pc=0x6, zero pushes; reset asserted during fault -> fault=0, pc=RESET_PC, fetch_count=0.
